// File: rtl/reg_file_responder_if.sv
// rtl/reg_file_responder_if.sv - operand request, reservation and write-back bus
interface reg_file_responder_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            rs1_read;
    logic [AW-1:0]   rs1_addr;
    logic            rs1_valid;
    logic [XLEN-1:0] rs1_value;
    logic            rs2_read;
    logic [AW-1:0]   rs2_addr;
    logic            rs2_valid;
    logic [XLEN-1:0] rs2_value;
    logic            rd_reserve;
    logic [AW-1:0]   rd_reserve_addr;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output rs1_read, rs1_addr, rs2_read, rs2_addr,
        output rd_reserve, rd_reserve_addr, wb_en, wb_addr, wb_data,
        input  rs1_valid, rs1_value, rs2_valid, rs2_value
    );

    modport slave (
        input  rs1_read, rs1_addr, rs2_read, rs2_addr,
        input  rd_reserve, rd_reserve_addr, wb_en, wb_addr, wb_data,
        output rs1_valid, rs1_value, rs2_valid, rs2_value
    );
endinterface

// File: rtl/reg_file_responder.sv
// rtl/reg_file_responder.sv - register file with pending scoreboard and stalling operand responder
module reg_file_responder #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_responder_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;

    logic            rd_req      [2];
    logic [AW-1:0]   rd_addr     [2];
    state_t          state_q     [2];
    state_t          state_d     [2];
    logic [AW-1:0]   wait_addr_q [2];
    logic [AW-1:0]   wait_addr_d [2];
    logic            valid_q     [2];
    logic            valid_d     [2];
    logic [XLEN-1:0] value_q     [2];
    logic [XLEN-1:0] value_d     [2];

    assign rd_req[0]  = bus.rs1_read;
    assign rd_req[1]  = bus.rs2_read;
    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;

    assign bus.rs1_valid = valid_q[0];
    assign bus.rs1_value = value_q[0];
    assign bus.rs2_valid = valid_q[1];
    assign bus.rs2_value = value_q[1];

    // Reservation is applied after the write so a same-edge reserve leaves the entry pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (bus.wb_en && bus.wb_addr != '0) begin
                regs[bus.wb_addr]    <= bus.wb_data;
                pending[bus.wb_addr] <= 1'b0;
            end
            if (bus.rd_reserve && bus.rd_reserve_addr != '0) begin
                pending[bus.rd_reserve_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]     <= ST_IDLE;
                wait_addr_q[p] <= '0;
                valid_q[p]     <= 1'b0;
                value_q[p]     <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]     <= state_d[p];
                wait_addr_q[p] <= wait_addr_d[p];
                valid_q[p]     <= valid_d[p];
                value_q[p]     <= value_d[p];
            end
        end
    end

    // Both ports share the same rules; a write-back to the requested index is forwarded directly.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p]     = state_q[p];
            wait_addr_d[p] = wait_addr_q[p];
            valid_d[p]     = 1'b0;
            value_d[p]     = value_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (rd_req[p]) begin
                        if (rd_addr[p] == '0) begin
                            valid_d[p] = 1'b1;
                            value_d[p] = '0;
                        end else if (bus.wb_en && bus.wb_addr == rd_addr[p]) begin
                            valid_d[p] = 1'b1;
                            value_d[p] = bus.wb_data;
                        end else if (!pending[rd_addr[p]]) begin
                            valid_d[p] = 1'b1;
                            value_d[p] = regs[rd_addr[p]];
                        end else begin
                            state_d[p]     = ST_WAIT;
                            wait_addr_d[p] = rd_addr[p];
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.wb_en && bus.wb_addr == wait_addr_q[p]) begin
                        valid_d[p] = 1'b1;
                        value_d[p] = bus.wb_data;
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_responder.sv
// tb/tb_reg_file_responder.sv - randomized scoreboard bench for reg_file_responder
module tb_reg_file_responder;
    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    exp_t q [2][$];

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_wait [2];
    int          m_waddr [2];

    reg_file_responder_if #(.XLEN(32), .AW(5)) bus ();

    reg_file_responder #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_port(input int p, input logic v, input logic [31:0] val);
        exp_t e;
        if (v) begin
            total++;
            if (q[p].size() == 0) begin
                bad++;
                $display("FAIL spurious_valid port%0d cyc=%0d got=%h required=no_pulse", p, cyc, val);
            end else begin
                e = q[p].pop_front();
                if (e.cyc != cyc || val !== e.val) begin
                    bad++;
                    $display("FAIL response port%0d got cyc=%0d val=%h required cyc=%0d val=%h",
                             p, cyc, val, e.cyc, e.val);
                end
            end
        end else if (q[p].size() > 0 && q[p][0].cyc <= cyc) begin
            e = q[p].pop_front();
            total++;
            bad++;
            $display("FAIL missing_valid port%0d cyc=%0d got=no_pulse required val=%h", p, cyc, e.val);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        check_port(0, bus.rs1_valid, bus.rs1_value);
        check_port(1, bus.rs2_valid, bus.rs2_value);
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            m_wait[p] = 1'b0;
            m_waddr[p] = 0;
            q[p].delete();
        end
    endtask

    task automatic set_idle();
        bus.rs1_read = 0; bus.rs1_addr = '0;
        bus.rs2_read = 0; bus.rs2_addr = '0;
        bus.rd_reserve = 0; bus.rd_reserve_addr = '0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    endtask

    // One clock of stimulus; the model decides each port's answer from the architectural rules.
    task automatic drive(input bit r1, input int a1, input bit r2, input int a2,
                         input bit res, input int ra, input bit wb, input int wa,
                         input logic [31:0] wd);
        bit   rd;
        int   a;
        exp_t e;
        @(negedge clk);
        bus.rs1_read = r1; bus.rs1_addr = 5'(a1);
        bus.rs2_read = r2; bus.rs2_addr = 5'(a2);
        bus.rd_reserve = res; bus.rd_reserve_addr = 5'(ra);
        bus.wb_en = wb; bus.wb_addr = 5'(wa); bus.wb_data = wd;
        for (int p = 0; p < 2; p++) begin
            rd = (p == 0) ? r1 : r2;
            a  = (p == 0) ? a1 : a2;
            e.cyc = cyc + 1;
            if (m_wait[p]) begin
                if (wb && wa == m_waddr[p]) begin
                    e.val = wd;
                    q[p].push_back(e);
                    m_wait[p] = 1'b0;
                end
            end else if (rd) begin
                if (a == 0) begin
                    e.val = '0;
                    q[p].push_back(e);
                end else if (wb && wa == a) begin
                    e.val = wd;
                    q[p].push_back(e);
                end else if (!m_pend[a]) begin
                    e.val = m_regs[a];
                    q[p].push_back(e);
                end else begin
                    m_wait[p] = 1'b1;
                    m_waddr[p] = a;
                end
            end
        end
        if (wb && wa != 0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
        end
        if (res && ra != 0) m_pend[ra] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (bus.rs1_valid !== 1'b0 || bus.rs2_valid !== 1'b0 ||
            bus.rs1_value !== '0 || bus.rs2_value !== '0) begin
            bad++;
            $display("FAIL %s got v1=%b v2=%b val1=%h val2=%h required all zero", tag,
                     bus.rs1_valid, bus.rs2_valid, bus.rs1_value, bus.rs2_value);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("reset_assert");
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        // write then read x5, reset mid-run, read x5 again
        drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h55);
        drive(1, 5, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 5, 1, 5, 0, 0, 0, 0, '0);
        do_reset();
        drive(1, 5, 0, 0, 0, 0, 0, 0, '0);
        idle(1);

        // write then read from both ports
        drive(0, 0, 0, 0, 0, 0, 1, 3, 32'd7);
        drive(1, 3, 1, 3, 0, 0, 0, 0, '0);
        idle(1);

        // x0 is hardwired and never stalls
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
        drive(1, 0, 0, 0, 1, 0, 0, 0, '0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, '0);
        idle(1);

        // same-edge bypass
        drive(0, 0, 1, 4, 0, 0, 1, 4, 32'hFFFF_FFFF);
        idle(1);

        // stall until write-back, then port is idle again
        drive(0, 0, 0, 0, 1, 6, 0, 0, '0);
        drive(1, 6, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, '0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1, 6, 32'd5);
        drive(1, 6, 0, 0, 0, 0, 0, 0, '0);
        idle(1);

        // reserve and write-back on the same edge leaves the register pending
        drive(0, 0, 0, 0, 1, 7, 1, 7, 32'h77);
        drive(0, 0, 1, 7, 0, 0, 0, 0, '0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 32'h78);
        idle(1);

        // back-to-back reads
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h11);
        drive(0, 0, 0, 0, 0, 0, 1, 2, 32'h22);
        drive(1, 1, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 2, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, '0);
        idle(1);

        // reset while waiting aborts the request
        drive(0, 0, 0, 0, 1, 9, 0, 0, '0);
        drive(1, 9, 1, 9, 0, 0, 0, 0, '0);
        idle(1);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h99);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 6, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 3, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)),
                  $urandom());
        end
        idle(3);

        total++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            bad++;
            $display("FAIL drain got q0=%0d q1=%0d required 0 0", q[0].size(), q[1].size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
